// File: rtl/lb_master.sv
// lb_master: local bus initiator turning a command stream into
// single or incrementing-address bursts of 1-256 words.
//
// Ports:
//   clk_lb, reset_n        clock, async active-low reset
//   cmd_valid/ready/wr/    command handshake: direction, start byte
//   addr/len               address, beats minus 1
//   wr_valid/ready/data    write data stream in
//   rd_valid/data/timeout  read result strobe out (no backpressure)
//   busy                   high whenever not idle
//   lb_wr, lb_rd,          local bus strobes, address, write data
//   lb_addr, lb_wr_d
//   lb_rd_d, lb_rd_rdy     responder read data and strobe
module lb_master #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter logic [31:0] RD_TO_DATA  = 32'hDEADBEEF
) (
    input  logic        clk_lb,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [31:0] cmd_addr,
    input  logic [7:0]  cmd_len,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        rd_timeout,
    output logic        busy,
    output logic        lb_wr,
    output logic        lb_rd,
    output logic [31:0] lb_addr,
    output logic [31:0] lb_wr_d,
    input  logic [31:0] lb_rd_d,
    input  logic        lb_rd_rdy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_RD_WAIT
    } state_t;

    localparam logic [15:0] TO_CYC = 16'(TIMEOUT_CYC);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  beats_q, beats_d;
    logic [15:0] cnt_q, cnt_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        wr_ready_q, wr_ready_d;
    logic        busy_q, busy_d;
    logic        wr_stb_q, wr_stb_d;
    logic        rd_stb_q, rd_stb_d;
    logic [31:0] lb_addr_q, lb_addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rd_valid_q, rd_valid_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_to_q, rd_to_d;

    always_ff @(posedge clk_lb or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            beats_q     <= '0;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            wr_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            wr_stb_q    <= 1'b0;
            rd_stb_q    <= 1'b0;
            lb_addr_q   <= '0;
            wdata_q     <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_to_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            beats_q     <= beats_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            wr_ready_q  <= wr_ready_d;
            busy_q      <= busy_d;
            wr_stb_q    <= wr_stb_d;
            rd_stb_q    <= rd_stb_d;
            lb_addr_q   <= lb_addr_d;
            wdata_q     <= wdata_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            rd_to_q     <= rd_to_d;
        end
    end

    // Outputs are computed from the next state so that every bus
    // strobe and handshake appears one cycle after its cause.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        beats_d    = beats_q;
        cnt_d      = cnt_q;
        wr_stb_d   = 1'b0;
        rd_stb_d   = 1'b0;
        lb_addr_d  = lb_addr_q;
        wdata_d    = wdata_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        rd_to_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    beats_d = cmd_len;
                    if (cmd_wr) begin
                        state_d = S_WR;
                    end else begin
                        // first read strobe leaves with the accept
                        state_d   = S_RD;
                        rd_stb_d  = 1'b1;
                        lb_addr_d = cmd_addr;
                    end
                end
            end
            S_WR: begin
                if (wr_valid) begin
                    wr_stb_d  = 1'b1;
                    lb_addr_d = addr_q;
                    wdata_d   = wr_data;
                    addr_d    = addr_q + 32'd4;
                    if (beats_q == 8'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        beats_d = beats_q - 8'd1;
                    end
                end
            end
            S_RD: begin
                // cnt counts cycles elapsed since the lb_rd pulse
                state_d = S_RD_WAIT;
                cnt_d   = 16'd1;
            end
            S_RD_WAIT: begin
                if (lb_rd_rdy) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = lb_rd_d;
                    if (beats_q == 8'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        beats_d   = beats_q - 8'd1;
                        addr_d    = addr_q + 32'd4;
                        lb_addr_d = addr_q + 32'd4;
                        rd_stb_d  = 1'b1;
                        state_d   = S_RD;
                    end
                end else if (cnt_q == TO_CYC) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = RD_TO_DATA;
                    rd_to_d    = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == S_IDLE);
        wr_ready_d  = (state_d == S_WR);
        busy_d      = (state_d != S_IDLE);
    end

    assign cmd_ready  = cmd_ready_q;
    assign wr_ready   = wr_ready_q;
    assign busy       = busy_q;
    assign lb_wr      = wr_stb_q;
    assign lb_rd      = rd_stb_q;
    assign lb_addr    = lb_addr_q;
    assign lb_wr_d    = wdata_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign rd_timeout = rd_to_q;

endmodule

// File: tb/tb_lb_master.sv
// tb_lb_master: directed testbench for lb_master with an 8-cycle
// read timeout and an inline 1-cycle responder model.
module tb_lb_master;

    logic        clk_lb = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_wr = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_data = '0;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_timeout;
    logic        busy;
    logic        lb_wr;
    logic        lb_rd;
    logic [31:0] lb_addr;
    logic [31:0] lb_wr_d;
    logic [31:0] lb_rd_d = '0;
    logic        lb_rd_rdy = 1'b0;

    int n_pass = 0;
    int n_total = 0;

    lb_master #(
        .TIMEOUT_CYC(8),
        .RD_TO_DATA (32'hDEADBEEF)
    ) dut (
        .clk_lb    (clk_lb),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_timeout(rd_timeout),
        .busy      (busy),
        .lb_wr     (lb_wr),
        .lb_rd     (lb_rd),
        .lb_addr   (lb_addr),
        .lb_wr_d   (lb_wr_d),
        .lb_rd_d   (lb_rd_d),
        .lb_rd_rdy (lb_rd_rdy)
    );

    always #5 clk_lb = ~clk_lb;

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk_lb);
        n_total++;
        if (cmd_ready !== 1'b1)
            $display("FAIL rst_cmd_ready got %b want 1", cmd_ready);
        else n_pass++;
        n_total++;
        if ({wr_ready, busy, lb_wr, lb_rd, rd_valid, rd_timeout} !== 6'b0)
            $display("FAIL rst_flags got %b want 000000",
                     {wr_ready, busy, lb_wr, lb_rd, rd_valid, rd_timeout});
        else n_pass++;
        n_total++;
        if ({lb_addr, lb_wr_d, rd_data} !== 96'h0)
            $display("FAIL rst_data got %h want 0",
                     {lb_addr, lb_wr_d, rd_data});
        else n_pass++;
        reset_n = 1'b1;
        @(negedge clk_lb);
        n_total++;
        if ({cmd_ready, busy} !== 2'b10)
            $display("FAIL rst_release got %b want 10", {cmd_ready, busy});
        else n_pass++;
    endtask

    task automatic test_single_write();
        int nw;
        cmd_valid = 1'b1;
        cmd_wr    = 1'b1;
        cmd_addr  = 32'h4;
        cmd_len   = 8'd0;
        @(negedge clk_lb);
        cmd_valid = 1'b0;
        n_total++;
        if ({cmd_ready, busy, wr_ready, lb_wr} !== 4'b0110)
            $display("FAIL sw_state got %b want 0110",
                     {cmd_ready, busy, wr_ready, lb_wr});
        else n_pass++;
        wr_valid = 1'b1;
        wr_data  = 32'hA5A50001;
        @(negedge clk_lb);
        wr_valid = 1'b0;
        n_total++;
        if (lb_wr !== 1'b1)
            $display("FAIL sw_lb_wr got %b want 1", lb_wr);
        else n_pass++;
        n_total++;
        if (lb_addr !== 32'h4)
            $display("FAIL sw_addr got %h want 00000004", lb_addr);
        else n_pass++;
        n_total++;
        if (lb_wr_d !== 32'hA5A50001)
            $display("FAIL sw_data got %h want a5a50001", lb_wr_d);
        else n_pass++;
        n_total++;
        if (cmd_ready !== 1'b1)
            $display("FAIL sw_done got %b want 1", cmd_ready);
        else n_pass++;
        nw = 0;
        repeat (3) begin
            @(negedge clk_lb);
            if (lb_wr) nw++;
        end
        n_total++;
        if (nw != 0)
            $display("FAIL sw_extra got %0d want 0", nw);
        else n_pass++;
        n_total++;
        if (lb_addr !== 32'h4 || cmd_ready !== 1'b1)
            $display("FAIL sw_hold got %h/%b want 00000004/1",
                     lb_addr, cmd_ready);
        else n_pass++;
    endtask

    task automatic test_write_wrap();
        logic [5:0]  wv = 6'b110011;
        logic [8:0]  ew = 9'b001100110;
        logic [31:0] ea [4] = '{32'hFFFFFFF8, 32'hFFFFFFFC,
                                32'h00000000, 32'h00000004};
        int ns = 0;
        int nb = 0;
        cmd_valid = 1'b1;
        cmd_wr    = 1'b1;
        cmd_addr  = 32'hFFFFFFF8;
        cmd_len   = 8'd3;
        @(negedge clk_lb);
        cmd_valid = 1'b0;
        for (int k = 0; k < 9; k++) begin
            n_total++;
            if (lb_wr !== ew[k])
                $display("FAIL ww_stb_c%0d got %b want %b",
                         k, lb_wr, ew[k]);
            else n_pass++;
            if (lb_wr === 1'b1 && ns < 4) begin
                n_total++;
                if (lb_addr !== ea[ns])
                    $display("FAIL ww_addr_b%0d got %h want %h",
                             ns, lb_addr, ea[ns]);
                else n_pass++;
                n_total++;
                if (lb_wr_d !== 32'hB0000000 + 32'(ns))
                    $display("FAIL ww_data_b%0d got %h want %h",
                             ns, lb_wr_d, 32'hB0000000 + 32'(ns));
                else n_pass++;
                ns++;
            end
            if (k < 6) begin
                wr_valid = wv[k];
                wr_data  = 32'hB0000000 + 32'(nb);
                if (wv[k]) nb++;
            end else begin
                wr_valid = 1'b0;
            end
            @(negedge clk_lb);
        end
        n_total++;
        if ({cmd_ready, wr_ready, busy} !== 3'b100)
            $display("FAIL ww_done got %b want 100",
                     {cmd_ready, wr_ready, busy});
        else n_pass++;
    endtask

    task automatic test_read_burst();
        logic [31:0] mem [4] = '{32'h12345678, 32'h0,
                                 32'h0, 32'hCAFEF00D};
        logic        pend = 1'b0;
        logic [1:0]  pidx = 2'd0;
        int nv = 0;
        int nr = 0;
        int lastv = -10;
        int both = 0;
        cmd_valid = 1'b1;
        cmd_wr    = 1'b0;
        cmd_addr  = 32'h0;
        cmd_len   = 8'd3;
        @(negedge clk_lb);
        cmd_valid = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (lb_rd && lb_wr) both++;
            if (lb_rd === 1'b1) begin
                n_total++;
                if (lb_addr !== 32'(nr * 4))
                    $display("FAIL rb_addr_b%0d got %h want %h",
                             nr, lb_addr, 32'(nr * 4));
                else n_pass++;
                nr++;
            end
            if (rd_valid === 1'b1) begin
                if (nv < 4) begin
                    n_total++;
                    if (rd_data !== mem[nv] || rd_timeout !== 1'b0)
                        $display("FAIL rb_data_b%0d got %h/%b want %h/0",
                                 nv, rd_data, rd_timeout, mem[nv]);
                    else n_pass++;
                end
                if (nv > 0) begin
                    n_total++;
                    if (t - lastv != 2)
                        $display("FAIL rb_gap_b%0d got %0d want 2",
                                 nv, t - lastv);
                    else n_pass++;
                end
                if (nv == 3) begin
                    n_total++;
                    if (cmd_ready !== 1'b1)
                        $display("FAIL rb_done got %b want 1", cmd_ready);
                    else n_pass++;
                end
                lastv = t;
                nv++;
            end
            lb_rd_rdy = pend;
            lb_rd_d   = pend ? mem[pidx] : 32'h0;
            pend      = lb_rd;
            pidx      = lb_addr[3:2];
            @(negedge clk_lb);
        end
        lb_rd_rdy = 1'b0;
        n_total++;
        if (nv != 4 || nr != 4)
            $display("FAIL rb_count got %0d/%0d want 4/4", nv, nr);
        else n_pass++;
        n_total++;
        if (both != 0)
            $display("FAIL rb_overlap got %0d want 0", both);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int nv = 0;
        int nr = 0;
        int tv = -1;
        logic [31:0] dv = '0;
        logic to = 1'b0;
        logic cr = 1'b0;
        cmd_valid = 1'b1;
        cmd_wr    = 1'b0;
        cmd_addr  = 32'h20;
        cmd_len   = 8'd2;
        @(negedge clk_lb);
        cmd_valid = 1'b0;
        n_total++;
        if (lb_rd !== 1'b1 || lb_addr !== 32'h20)
            $display("FAIL to_first got %b/%h want 1/00000020",
                     lb_rd, lb_addr);
        else n_pass++;
        for (int t = 0; t < 15; t++) begin
            if (lb_rd === 1'b1) nr++;
            if (t == 5) begin
                n_total++;
                if (busy !== 1'b1 || rd_valid !== 1'b0)
                    $display("FAIL to_wait got %b/%b want 1/0",
                             busy, rd_valid);
                else n_pass++;
            end
            if (rd_valid === 1'b1) begin
                nv++;
                tv = t;
                dv = rd_data;
                to = rd_timeout;
                cr = cmd_ready;
            end
            @(negedge clk_lb);
        end
        n_total++;
        if (nr != 1 || nv != 1)
            $display("FAIL to_count got rd=%0d valid=%0d want 1/1", nr, nv);
        else n_pass++;
        n_total++;
        if (tv != 9)
            $display("FAIL to_latency got %0d want 9", tv);
        else n_pass++;
        n_total++;
        if (dv !== 32'hDEADBEEF || to !== 1'b1 || cr !== 1'b1)
            $display("FAIL to_result got %h/%b/%b want deadbeef/1/1",
                     dv, to, cr);
        else n_pass++;
        nv = 0;
        lb_rd_rdy = 1'b1;
        lb_rd_d   = 32'h1111;
        repeat (2) begin
            @(negedge clk_lb);
            if (rd_valid) nv++;
        end
        lb_rd_rdy = 1'b0;
        @(negedge clk_lb);
        if (rd_valid) nv++;
        n_total++;
        if (nv != 0)
            $display("FAIL stray_rdy got %0d want 0", nv);
        else n_pass++;
    endtask

    task automatic test_boundary_rdy();
        int nv = 0;
        int tv = -1;
        logic [31:0] dv = '0;
        logic to = 1'b1;
        logic cr = 1'b0;
        cmd_valid = 1'b1;
        cmd_wr    = 1'b0;
        cmd_addr  = 32'h40;
        cmd_len   = 8'd0;
        @(negedge clk_lb);
        cmd_valid = 1'b0;
        n_total++;
        if (lb_rd !== 1'b1 || lb_addr !== 32'h40)
            $display("FAIL bd_first got %b/%h want 1/00000040",
                     lb_rd, lb_addr);
        else n_pass++;
        for (int t = 0; t < 13; t++) begin
            if (rd_valid === 1'b1) begin
                nv++;
                tv = t;
                dv = rd_data;
                to = rd_timeout;
                cr = cmd_ready;
            end
            lb_rd_rdy = (t == 8);
            lb_rd_d   = (t == 8) ? 32'h5A5A1234 : 32'h0;
            @(negedge clk_lb);
        end
        lb_rd_rdy = 1'b0;
        n_total++;
        if (nv != 1 || tv != 9)
            $display("FAIL bd_timing got n=%0d t=%0d want 1/9", nv, tv);
        else n_pass++;
        n_total++;
        if (dv !== 32'h5A5A1234 || to !== 1'b0 || cr !== 1'b1)
            $display("FAIL bd_result got %h/%b/%b want 5a5a1234/0/1",
                     dv, to, cr);
        else n_pass++;
    endtask

    task automatic test_long_burst();
        int ns = 0;
        int first = -1;
        int last = -1;
        logic [31:0] la = '0;
        cmd_valid = 1'b1;
        cmd_wr    = 1'b1;
        cmd_addr  = 32'h1000;
        cmd_len   = 8'd255;
        @(negedge clk_lb);
        cmd_valid = 1'b0;
        wr_valid  = 1'b1;
        for (int t = 0; t < 300; t++) begin
            if (lb_wr === 1'b1) begin
                ns++;
                if (first < 0) first = t;
                last = t;
                la = lb_addr;
            end
            wr_data = 32'(t);
            @(negedge clk_lb);
        end
        wr_valid = 1'b0;
        n_total++;
        if (ns != 256)
            $display("FAIL lb_count got %0d want 256", ns);
        else n_pass++;
        n_total++;
        if (last - first != 255)
            $display("FAIL lb_span got %0d want 255", last - first);
        else n_pass++;
        n_total++;
        if (la !== 32'h13FC || cmd_ready !== 1'b1)
            $display("FAIL lb_end got %h/%b want 000013fc/1",
                     la, cmd_ready);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int nw = 0;
        cmd_valid = 1'b1;
        cmd_wr    = 1'b1;
        cmd_addr  = 32'h200;
        cmd_len   = 8'd7;
        @(negedge clk_lb);
        cmd_valid = 1'b0;
        wr_valid  = 1'b1;
        wr_data   = 32'h77;
        @(negedge clk_lb);
        n_total++;
        if (lb_wr !== 1'b1)
            $display("FAIL rm_active got %b want 1", lb_wr);
        else n_pass++;
        #1 reset_n = 1'b0;
        #1;
        n_total++;
        if ({lb_wr, lb_rd, cmd_ready, busy} !== 4'b0010)
            $display("FAIL rm_async got %b want 0010",
                     {lb_wr, lb_rd, cmd_ready, busy});
        else n_pass++;
        @(negedge clk_lb);
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk_lb);
            if (lb_wr) nw++;
        end
        wr_valid = 1'b0;
        n_total++;
        if (nw != 0 || cmd_ready !== 1'b1)
            $display("FAIL rm_after got %0d/%b want 0/1", nw, cmd_ready);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_write_wrap();
        test_read_burst();
        test_timeout();
        test_boundary_rdy();
        test_long_burst();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lb_master.md
# lb_master

Local bus initiator that drives the `lb_wr`/`lb_rd`/`lb_addr`/`lb_wr_d` side of the team's 32-bit local bus and collects `lb_rd_d`/`lb_rd_rdy` from responder cores. It turns a simple command stream into single or incrementing-address burst transactions of 1–256 words, and streams write data in and read data out. It guards every read with a timeout so a missing responder cannot hang the bus. It sits between the host-side command decoder and the core register banks.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 255: number of cycles after an `lb_rd` pulse in which `lb_rd_rdy` is accepted; range 1–65535.
- `RD_TO_DATA`, default 32'hDEADBEEF: value returned on `rd_data` for a timed-out read.

Ports:
- `clk_lb`  in  1  single clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`.
- `cmd_wr`  in  1  1 = write burst, 0 = read burst.
- `cmd_addr`  in  32  start byte address.
- `cmd_len`  in  8  beats minus 1.
- `wr_valid`  in  1  write data beat present.
- `wr_ready`  out  1  write beat accepted when `wr_valid & wr_ready`.
- `wr_data`  in  32  write data beat.
- `rd_valid`  out  1  one-cycle read result strobe; no backpressure.
- `rd_data`  out  32  read result.
- `rd_timeout`  out  1  qualifies `rd_valid`: the beat timed out.
- `busy`  out  1  high in any state other than IDLE.
- `lb_wr`, `lb_rd`  out  1 each  single-cycle transaction strobes.
- `lb_addr`, `lb_wr_d`  out  32 each  address and write data.
- `lb_rd_d`  in  32  responder read data.
- `lb_rd_rdy`  in  1  responder read-data strobe.

## Operation
- Reset values: all outputs are 0 except `cmd_ready` = 1. The FSM is in IDLE and internal counters are cleared. Reset asserted mid-burst aborts the burst immediately; no further `lb_*` strobes are issued.
- The FSM has four states: IDLE, WR, RD, RD_WAIT.
- **IDLE**
  - `cmd_ready` = 1, `wr_ready` = 0.
  - On command accept, latch `cmd_addr` and `cmd_len`. `beats_left` = `cmd_len`.
  - Go to WR if `cmd_wr` = 1, else RD.
- **WR**
  - `wr_ready` = 1.
  - Each accepted beat produces `lb_wr` = 1 for one cycle, with `lb_addr` = current address and `lb_wr_d` = `wr_data`.
  - The address then advances by 4.
  - When the accepted beat has `beats_left` = 0, go to IDLE; otherwise decrement `beats_left`.
  - A stall (`wr_valid` = 0) holds the state and produces no `lb_wr`.
- **RD**
  - Issue `lb_rd` = 1 for one cycle with `lb_addr` = current address.
  - Clear the timeout counter and go to RD_WAIT.
- **RD_WAIT**
  - On `lb_rd_rdy`: capture `lb_rd_d`. If `beats_left` = 0 go to IDLE, else decrement, advance the address by 4, and go to RD.
  - If the counter reaches `TIMEOUT_CYC` without `lb_rd_rdy`: return `RD_TO_DATA` with `rd_timeout` = 1, abort the remaining beats, and go to IDLE.
- Address arithmetic is modulo 2^32: 32'hFFFFFFFC + 4 = 32'h00000000.
- `lb_addr` and `lb_wr_d` hold their last values between strobes.
- `lb_rd_rdy` seen in IDLE, WR, or RD (stray or late) is ignored and produces no `rd_valid`.
- `lb_wr` and `lb_rd` are never high in the same cycle.
- `cmd_*` inputs are ignored outside IDLE.

## Timing
- All outputs are registered.
- Write: a beat accepted in cycle N gives `lb_wr` high in N+1. With `wr_valid` held high, an L-beat burst gives L consecutive `lb_wr` cycles.
- Write completion: `cmd_ready` returns high in the cycle after the last beat is accepted.
- Read: a command accepted in cycle N gives `lb_rd` high in N+1.
- Read data: `lb_rd_rdy` sampled in cycle M gives `rd_valid` with `rd_data` = `lb_rd_d` in M+1. The next beat's `lb_rd` is also in M+1.
- With a 1-cycle responder, read throughput is 2 cycles per beat.
- `lb_rd_rdy` is accepted in any of cycles P+1 … P+`TIMEOUT_CYC` after an `lb_rd` pulse in cycle P. If it is absent through P+`TIMEOUT_CYC`, then `rd_valid` = `rd_timeout` = 1 in P+`TIMEOUT_CYC`+1, and `cmd_ready` = 1 in the same cycle.
- Read completion: `cmd_ready` is high in the same cycle as the last `rd_valid`.
- `busy` is the registered inverse of `cmd_ready`.

## Test plan
- Reset: hold `reset_n` low, then release → all outputs 0, `cmd_ready` = 1. Assert `reset_n` low mid-burst → `lb_wr`/`lb_rd` drop to 0 in the same cycle and `cmd_ready` = 1 after release.
- Single write: write to 32'h04 with data 32'hA5A5_0001 → exactly one `lb_wr` cycle with `lb_addr` = 32'h04 and `lb_wr_d` = 32'hA5A5_0001; `cmd_ready` is high on the following cycle.
- Write burst with wrap and stall:
  - Stimulus: `cmd_addr` = 32'hFFFFFFF8, `cmd_len` = 3, `wr_valid` dropped for 2 cycles after beat 1.
  - Response: `lb_addr` sequence FFFFFFF8, FFFFFFFC, 00000000, 00000004, with a 2-cycle gap in `lb_wr`.
- Read burst against a 1-cycle responder model preloaded with 12345678, 0, 0, CAFEF00D at 0x00–0x0C:
  - Stimulus: `cmd_addr` = 0, `cmd_len` = 3.
  - Response: four `rd_valid` strobes 2 cycles apart carrying those values, `rd_timeout` = 0.
- Timeout: `TIMEOUT_CYC` = 8, no responder, 3-beat read → a single `rd_valid` with `rd_data` = DEADBEEF and `rd_timeout` = 1, 9 cycles after `lb_rd`; no second `lb_rd`. A stray `lb_rd_rdy` in IDLE produces no `rd_valid`.
- Boundary: `lb_rd_rdy` arriving exactly `TIMEOUT_CYC` cycles after `lb_rd` → normal data, `rd_timeout` = 0. `cmd_len` = 255 write burst → exactly 256 `lb_wr` strobes.
